// File: rtl/bsg_tx.sv
// Serial transmitter: two latched payload bytes sent LSB-first between a start and a stop bit, CLKDIV cycles per bit.
// Frame starts the edge TXENABLE is seen in IDLE; only rst aborts a frame, and STOP always returns through one IDLE cycle.
module bsg_tx #(
  parameter int CLKDIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] controle1,
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  output logic [4:0] controle2,
  output logic       tx_out,
  output logic       irq
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [7:0] DivReload = 8'(CLKDIV - 1);

  state_t      state_q;
  logic [7:0]  div_q;
  logic [4:0]  idx_q;
  logic [15:0] shift_q;
  logic        tx_q;
  logic        busy_q;
  logic        par_q;
  logic [2:0]  cnt_q;
  logic        irq_q;
  logic        bit_done;

  assign bit_done = (div_q == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= 8'd0;
      idx_q   <= 5'd0;
      shift_q <= 16'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      par_q   <= 1'b0;
      cnt_q   <= 3'd0;
      irq_q   <= 1'b0;
    end else begin
      irq_q <= controle1[2] & controle1[1];
      case (state_q)
        IDLE: begin
          if (controle1[0]) begin
            state_q <= START;
            shift_q <= {data2, data1};
            busy_q  <= 1'b1;
            tx_q    <= 1'b0;
            div_q   <= DivReload;
          end
        end
        START: begin
          if (bit_done) begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[15:1]};
            idx_q   <= 5'd0;
            div_q   <= DivReload;
          end else begin
            div_q <= div_q - 8'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            div_q <= DivReload;
            if (idx_q == 5'd15) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              // Bit for the next slot is already at shift_q[0].
              idx_q   <= idx_q + 5'd1;
              tx_q    <= shift_q[0];
              shift_q <= {1'b0, shift_q[15:1]};
            end
          end else begin
            div_q <= div_q - 8'd1;
          end
        end
        STOP: begin
          if (bit_done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
            par_q   <= ~par_q;
            cnt_q   <= cnt_q + 3'd1;
          end else begin
            div_q <= div_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign controle2 = {cnt_q, par_q, busy_q};
  assign tx_out    = tx_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_bsg_tx.sv
// Directed bench for bsg_tx: frame vectors, back-to-back, count wrap, mid-frame reset, CLKDIV=1 and irq.
module tb_bsg_tx;
  localparam int CLKDIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] controle1;
  logic [7:0] data1, data2;
  logic [4:0] controle2, controle2_f;
  logic       tx_out, tx_f, irq, irq_f;

  int checks = 0;
  int errors = 0;
  int exp_cnt;
  bit exp_par;

  always #5 clk = ~clk;

  bsg_tx #(.CLKDIV(CLKDIV)) u_dut (
    .clk(clk), .rst(rst), .controle1(controle1), .data1(data1), .data2(data2),
    .controle2(controle2), .tx_out(tx_out), .irq(irq)
  );

  bsg_tx #(.CLKDIV(1)) u_fast (
    .clk(clk), .rst(rst), .controle1(controle1), .data1(data1), .data2(data2),
    .controle2(controle2_f), .tx_out(tx_f), .irq(irq_f)
  );

  typedef struct {
    logic [7:0]  d1;
    logic [7:0]  d2;
    logic [17:0] bits;  // [0]=start, [8:1]=data1, [16:9]=data2, [17]=stop
    int          chg;   // cycle at which data1 is overwritten with 0xFF, -1 = never
    bit          hold;
  } frame_vec_t;

  typedef struct {
    logic [2:0] ctl;
    logic       exp_irq;
  } irq_vec_t;

  frame_vec_t fv[4];
  irq_vec_t   iv[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    exp_par = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] d1, input logic [7:0] d2, input logic [17:0] bits,
                           input int chg, input bit hold);
    data1 = d1;
    data2 = d2;
    controle1[0] = 1'b1;
    tick();
    if (!hold) controle1[0] = 1'b0;
    for (int c = 0; c < 18 * CLKDIV; c++) begin
      if (c == chg) data1 = 8'hFF;
      chk("frame_tx", tx_out, bits[c / CLKDIV]);
      chk("frame_status", controle2[0], 1);
      tick();
    end
    exp_cnt = (exp_cnt + 1) % 8;
    exp_par = ~exp_par;
    chk("idle_tx", tx_out, 1);
    chk("idle_status", controle2[0], 0);
    chk("idle_ctl2", controle2, {exp_cnt[2:0], exp_par, 1'b0});
  endtask

  initial begin
    logic [17:0] bits5a;
    logic        prev_irq;

    fv[0] = '{8'hA5, 8'h3C, 18'b1_00111100_10100101_0, -1, 1'b0};
    fv[1] = '{8'hA5, 8'h3C, 18'b1_00111100_10100101_0, 4 * CLKDIV + 1, 1'b0};
    fv[2] = '{8'h00, 8'hFF, 18'b1_11111111_00000000_0, -1, 1'b0};
    fv[3] = '{8'h81, 8'h7E, 18'b1_01111110_10000001_0, -1, 1'b0};
    iv[0] = '{3'b110, 1'b1};
    iv[1] = '{3'b100, 1'b0};
    iv[2] = '{3'b110, 1'b1};
    iv[3] = '{3'b010, 1'b0};
    iv[4] = '{3'b000, 1'b0};
    bits5a = 18'b1_11000011_01011010_0;

    rst = 1'b1;
    controle1 = 3'b111;
    data1 = 8'h00;
    data2 = 8'h00;
    tick();
    tick();
    chk("rst_tx", tx_out, 1);
    chk("rst_ctl2", controle2, 5'b00000);
    chk("rst_irq", irq, 0);
    chk("rst_fast_tx", tx_f, 1);
    controle1 = 3'b000;
    do_reset();

    // Frame vectors, including REQ example and data1 overwrite during bit 3
    for (int i = 0; i < 4; i++) begin
      run_frame(fv[i].d1, fv[i].d2, fv[i].bits, fv[i].chg, fv[i].hold);
      if (i == 0) chk("first_frame_ctl2", controle2, 5'b00110);
    end
    tick();
    chk("stay_idle", controle2[0], 0);

    // Three back-to-back frames, enable dropped during the third
    do_reset();
    run_frame(8'hA5, 8'h3C, 18'b1_00111100_10100101_0, -1, 1'b1);
    run_frame(8'hA5, 8'h3C, 18'b1_00111100_10100101_0, -1, 1'b1);
    run_frame(8'hA5, 8'h3C, 18'b1_00111100_10100101_0, -1, 1'b0);
    chk("b2b_ctl2", controle2, 5'b01110);
    tick();
    tick();
    chk("b2b_no_fourth", controle2[0], 0);
    chk("b2b_no_fourth_tx", tx_out, 1);

    // Nine frames: count wraps to 1, parity ends at 1
    do_reset();
    for (int i = 0; i < 9; i++) run_frame(8'h5A, 8'hC3, bits5a, -1, 1'b0);
    chk("wrap_ctl2", controle2, 5'b00110);

    // Reset at cycle 20 of a frame
    do_reset();
    data1 = 8'hA5;
    data2 = 8'h3C;
    controle1[0] = 1'b1;
    tick();
    controle1[0] = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    chk("pre_rst_status", controle2[0], 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_tx", tx_out, 1);
    chk("midrst_status", controle2[0], 0);
    chk("midrst_ctl2", controle2, 5'b00000);
    tick();
    chk("midrst_stays_idle", controle2, 5'b00000);

    // CLKDIV=1 instance: one cycle per bit
    do_reset();
    data1 = 8'h5A;
    data2 = 8'hC3;
    controle1[0] = 1'b1;
    tick();
    controle1[0] = 1'b0;
    for (int c = 0; c < 18; c++) begin
      chk("fast_tx", tx_f, bits5a[c]);
      chk("fast_status", controle2_f[0], 1);
      tick();
    end
    chk("fast_idle_tx", tx_f, 1);
    chk("fast_ctl2", controle2_f, 5'b00110);
    for (int c = 0; c < 60; c++) tick();

    // irq is INTFLAG & INTMSK, one cycle late
    do_reset();
    prev_irq = 1'b0;
    for (int i = 0; i < 5; i++) begin
      controle1 = iv[i].ctl;
      #1;
      chk("irq_before_edge", irq, prev_irq);
      tick();
      chk("irq_after_edge", irq, iv[i].exp_irq);
      prev_irq = iv[i].exp_irq;
    end
    chk("irq_no_frame", controle2[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
